spm_seq_mult: RTL



---
 rtl/spm_pkg.sv | 17 +
 rtl/spm_csa_cell.sv | 34 +++
 rtl/spm_seq_mult.sv | 105 ++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic CSA_RST = 1'b0;

  // Counter must reach 2*width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// Single-bit carry-save cell: adds one partial-product bit, the incoming sum and its own carry.
module spm_csa_cell
  import spm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic x_bit,
  input  logic y_bit,
  input  logic sum_in,
  output logic sum
);

  logic carry;
  logic pp;

  assign pp = x_bit & y_bit;

  // NOTE: non-blocking so every cell sees its neighbour's pre-edge sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum   <= CSA_RST;
      carry <= CSA_RST;
    end else if (clear) begin
      sum   <= CSA_RST;
      carry <= CSA_RST;
    end else if (enable) begin
      sum   <= pp ^ sum_in ^ carry;
      carry <= (pp & sum_in) | (pp & carry) | (sum_in & carry);
    end
  end

endmodule

// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: x loaded in parallel, y streamed LSB-first, 2*WIDTH-bit product
// streamed LSB-first through a chain of WIDTH carry-save cells.
module spm_seq_mult
  import spm_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] x,
  input  logic             signed_mode,
  input  logic             en,
  input  logic             y,
  output logic             p,
  output logic             p_valid,
  output logic             p_last,
  output logic             done
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_YMSB = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_YEND = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] s;
  logic             signed_q;
  logic             y_msb;
  logic             y_bit;
  logic             accept;
  logic             step;

  assign ready  = (state == IDLE);
  assign accept = ready & start;
  assign step   = (state == RUN) & en;
  assign y_bit  = (cnt < CNT_YEND) ? y : (signed_q & y_msb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (en && cnt == CNT_LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      x_q      <= '0;
      signed_q <= 1'b0;
      y_msb    <= 1'b0;
      p_valid  <= 1'b0;
      p_last   <= 1'b0;
    end else begin
      p_valid <= step;
      p_last  <= step && (cnt == CNT_LAST);
      if (accept) begin
        x_q      <= x;
        signed_q <= SIGNED_EN & signed_mode;
        cnt      <= '0;
        y_msb    <= 1'b0;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_YMSB) y_msb <= y;
      end
    end
  end

  assign done = p_last;
  assign p    = p_valid & s[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic sum_in;
    if (i == WIDTH - 1) begin : g_msb
      // Signed: this cell carries negative weight; recycling its own sum sign-extends the accumulator.
      assign sum_in = signed_q & s[i];
    end else begin : g_mid
      assign sum_in = s[i+1];
    end
    spm_csa_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .enable (step),
      .clear  (accept),
      .x_bit  (x_q[i]),
      .y_bit  (y_bit),
      .sum_in (sum_in),
      .sum    (s[i])
    );
  end

endmodule
